br_fifo_shared_dynamic_push_credit_arb_sender: RTL and testbench
================================================================

# br_fifo_shared_dynamic_push_credit_arb_sender

Upstream feeder for the shared dynamic multi-FIFO's credit-based push interface. It accepts NumFifos independent valid/ready source streams, one per logical FIFO, and round-robin arbitrates among them. It also tracks push credits returned by the shared FIFO and issues at most one registered push per cycle, tagged with the winning source's FIFO id. This version supports a single write port; the downstream shared FIFO is instantiated with NumWritePorts = 1.

## Interface
- NumFifos, 2: number of sources/logical FIFOs; must be >= 2.
- Width, 1: data width; must be >= 1.
- MaxCredit, 3: credit counter capacity; equals the downstream Depth; must be >= 1.
- FifoIdWidth (localparam): br_math::clamped_clog2(NumFifos).
- CountWidth (localparam): $clog2(MaxCredit + 1).
- clk  input  1  sole clock; all state is on rising edge.
- rst  input  1  asynchronous, active-high reset.
- src_valid  input  NumFifos  per-source valid.
- src_ready  output  NumFifos  per-source ready; at most one bit set (onehot0).
- src_data  input  NumFifos x Width  per-source data.
- push_sender_in_reset  output  1  tells the receiver this sender is in reset.
- push_receiver_in_reset  input  1  the receiver is in reset.
- push_credit  input  1  one credit returned this cycle.
- push_valid  output  1  registered push.
- push_data  output  Width  registered push data.
- push_fifo_id  output  FifoIdWidth  registered destination FIFO.
- credit_stall  input  1  blocks new grants; credit returns are still counted.
- credit_withhold  input  CountWidth  credits hidden from issue; quasi-static.
- credit_count  output  CountWidth  credits held.
- credit_available  output  CountWidth  credits usable for issue.

## Operation
- Reset values:
  - push_valid = 0, push_data = 0, push_fifo_id = 0.
  - push_sender_in_reset = 1.
  - credit_count = 0, credit_available = 0.
  - Round-robin pointer = 0.
- push_sender_in_reset: flop, asynchronously set by rst. It clears on the first clk edge after rst deasserts.
- credit_available = credit_count - credit_withhold when credit_count > credit_withhold; otherwise 0.
- can_issue = (credit_available != 0) & !credit_stall & !push_receiver_in_reset & !push_sender_in_reset.
- Arbitration (combinational):
  - The request set is src_valid.
  - The grant goes to the first requester at or after the pointer, wrapping modulo NumFifos.
  - src_ready[i] = grant[i] & can_issue.
- Issue = |(src_valid & src_ready). On issue, the next cycle shows:
  - push_valid = 1
  - push_data = src_data of the granted source
  - push_fifo_id = the granted index.
  Otherwise push_valid = 0 next cycle; push_data and push_fifo_id hold their last values.
- Pointer update: on issue, the pointer becomes (granted index + 1) mod NumFifos. With no issue the pointer holds.
- Credit update: credit_count_next = credit_count + push_credit - issue.
  - A credit returned and a credit spent in the same cycle cancel, leaving the count unchanged.
  - Overflow (count == MaxCredit, push_credit = 1, no issue) is an integration error. An assertion fires and the RTL saturates at MaxCredit.
- While push_receiver_in_reset = 1:
  - credit_count is synchronously cleared to 0 and returned credits are ignored.
  - No grants are made.
  - The receiver re-grants its full depth after it leaves reset.
- Integration assertions:
  - src_data is stable while src_valid is high and not accepted.
  - credit_withhold changes only while credit_count == 0.
  - push_credit = 0 while push_sender_in_reset = 1.

## Timing
- Source acceptance to push_valid: 1 cycle.
- Credit received in cycle t is counted in credit_count at t+1. It can first be spent (src_ready) in cycle t+1; there is no same-cycle bypass.
- Sustained throughput is 1 push/cycle when credits are continuously available.
- A single source saturates the port when it is the only requester.
- With k requesters, each is granted at least once every k issues.
- rst asserted mid-operation:
  - All outputs go to their reset values immediately, asynchronously.
  - In-flight credits are lost. The receiver is expected to be reset as well.
- push_receiver_in_reset asserted mid-operation: a push already registered still presents for its one cycle. No further pushes are issued.

## Test plan
- Reset, then the receiver returns 3 single credits in cycles 1-3, then sources 0 and 1 request continuously:
  - credit_count goes 0, 1, 2, 3.
  - push_fifo_id alternates 0, 1, 0.
  - After 3 pushes credit_count = 0 and src_ready = 0.
- credit_count = 1, push_credit = 1, one issue in the same cycle: credit_count stays 1 and push_valid = 1 the next cycle.
- credit_count = 3, credit_withhold = 2, a single requester: exactly one push issues, then src_ready stays low while credit_count = 2 and credit_available = 0.
- credit_stall held high for 4 cycles with credits and requests present:
  - src_ready = 0 and push_valid = 0 throughout.
  - Credits returned during the stall still increment credit_count.
- All 4 sources valid with NumFifos = 4 and unlimited credits: the grant order is 0, 1, 2, 3, 0 and push_data matches each source's data.
- Assert push_receiver_in_reset with credit_count = 2: the next cycle credit_count = 0 and no pushes issue. After deassertion plus 1 returned credit, exactly one push issues.

Source files
------------

// File: rtl/br_fifo_shared_dynamic_push_credit_arb_sender.sv
// Credit-based push sender for the shared dynamic multi-FIFO: round-robin arbitration
// over per-FIFO source streams, credit tracking, and one registered push per cycle.

module br_fifo_shared_dynamic_push_credit_arb_sender_chk #(
    parameter int NumFifos   = 2,
    parameter int Width      = 1,
    parameter int MaxCredit  = 3,
    parameter int CountWidth = 2
) (
    input logic                               clk,
    input logic                               rst,
    input logic [NumFifos-1:0]                src_valid,
    input logic [NumFifos-1:0]                src_ready,
    input logic [NumFifos-1:0][Width-1:0]     src_data,
    input logic                               push_credit,
    input logic                               push_sender_in_reset,
    input logic                               push_receiver_in_reset,
    input logic                               issue,
    input logic [CountWidth-1:0]              credit_withhold,
    input logic [CountWidth-1:0]              credit_count
);

    logic                           armed_r;
    logic [NumFifos-1:0]            pend_r;
    logic [NumFifos-1:0][Width-1:0] data_r;
    logic [CountWidth-1:0]          withhold_r;

    // Capture previous-cycle handshake and quasi-static values for the integration checks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            armed_r    <= 1'b0;
            pend_r     <= {NumFifos{1'b0}};
            data_r     <= {(NumFifos * Width){1'b0}};
            withhold_r <= {CountWidth{1'b0}};
        end else begin
            armed_r    <= 1'b1;
            pend_r     <= src_valid & ~src_ready;
            data_r     <= src_data;
            withhold_r <= credit_withhold;
        end
    end

    // Integration rules the surrounding logic must honour.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(credit_count == CountWidth'(MaxCredit) && push_credit && !issue
                      && !push_receiver_in_reset))
                else $error("push credit overflow");
            assert (!(push_sender_in_reset && push_credit))
                else $error("push credit returned while sender in reset");
            assert (!armed_r || (credit_withhold == withhold_r)
                    || (credit_count == {CountWidth{1'b0}}))
                else $error("credit_withhold changed while credits held");
            for (int i = 0; i < NumFifos; i++) begin
                assert (!(pend_r[i] && src_valid[i]) || (src_data[i] == data_r[i]))
                    else $error("src_data unstable while waiting on source %0d", i);
            end
        end
    end

endmodule

module br_fifo_shared_dynamic_push_credit_arb_sender #(
    parameter  int NumFifos    = 2,
    parameter  int Width       = 1,
    parameter  int MaxCredit   = 3,
    localparam int FifoIdWidth = (NumFifos > 1) ? $clog2(NumFifos) : 1,
    localparam int CountWidth  = $clog2(MaxCredit + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NumFifos-1:0]            src_valid,
    output logic [NumFifos-1:0]            src_ready,
    input  logic [NumFifos-1:0][Width-1:0] src_data,
    output logic                           push_sender_in_reset,
    input  logic                           push_receiver_in_reset,
    input  logic                           push_credit,
    output logic                           push_valid,
    output logic [Width-1:0]               push_data,
    output logic [FifoIdWidth-1:0]         push_fifo_id,
    input  logic                           credit_stall,
    input  logic [CountWidth-1:0]          credit_withhold,
    output logic [CountWidth-1:0]          credit_count,
    output logic [CountWidth-1:0]          credit_available
);

    logic                   sender_in_reset_r;
    logic [CountWidth-1:0]  credit_count_r;
    logic [CountWidth-1:0]  credit_count_next_s;
    logic [CountWidth-1:0]  credit_available_s;
    logic [FifoIdWidth-1:0] ptr_r;
    logic [FifoIdWidth-1:0] cand_s;
    logic [FifoIdWidth-1:0] grant_idx_s;
    logic                   grant_found_s;
    logic                   can_issue_s;
    logic                   issue_s;
    logic [NumFifos-1:0]    src_ready_s;
    logic                   push_valid_r;
    logic [Width-1:0]       push_data_r;
    logic [FifoIdWidth-1:0] push_fifo_id_r;

    // Index arithmetic modulo NumFifos, valid for non-power-of-two source counts.
    function automatic logic [FifoIdWidth-1:0] wrap_idx(input logic [FifoIdWidth-1:0] base,
                                                         input logic [31:0] off);
        logic [31:0] sum;
        sum = 32'(base) + off;
        if (sum >= 32'(NumFifos)) begin
            sum = sum - 32'(NumFifos);
        end else begin
            sum = sum;
        end
        return sum[FifoIdWidth-1:0];
    endfunction

    // Sender-in-reset flag: set asynchronously, released by the first clock after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sender_in_reset_r <= 1'b1;
        end else begin
            sender_in_reset_r <= 1'b0;
        end
    end

    // Credits not hidden by the withhold amount.
    always_comb begin
        credit_available_s = {CountWidth{1'b0}};
        if (credit_count_r > credit_withhold) begin
            credit_available_s = credit_count_r - credit_withhold;
        end else begin
            credit_available_s = {CountWidth{1'b0}};
        end
    end

    assign can_issue_s = (credit_available_s != {CountWidth{1'b0}}) && !credit_stall
                         && !push_receiver_in_reset && !sender_in_reset_r;

    // Round-robin search: first requester at or after the pointer.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = {FifoIdWidth{1'b0}};
        cand_s        = {FifoIdWidth{1'b0}};
        for (int k = 0; k < NumFifos; k++) begin
            cand_s = wrap_idx(ptr_r, 32'(k));
            if (!grant_found_s && src_valid[cand_s]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand_s;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Ready only for the winner, and only when a credit can be spent this cycle.
    always_comb begin
        src_ready_s = {NumFifos{1'b0}};
        if (grant_found_s && can_issue_s) begin
            src_ready_s[grant_idx_s] = 1'b1;
        end else begin
            src_ready_s = {NumFifos{1'b0}};
        end
    end

    assign issue_s = |(src_valid & src_ready_s);

    // Credit count next state; a return and a spend in the same cycle cancel.
    always_comb begin
        credit_count_next_s = credit_count_r;
        if (push_receiver_in_reset) begin
            credit_count_next_s = {CountWidth{1'b0}};
        end else if (push_credit && !issue_s) begin
            if (credit_count_r == CountWidth'(MaxCredit)) begin
                credit_count_next_s = credit_count_r;
            end else begin
                credit_count_next_s = credit_count_r + {{(CountWidth-1){1'b0}}, 1'b1};
            end
        end else if (!push_credit && issue_s) begin
            credit_count_next_s = credit_count_r - {{(CountWidth-1){1'b0}}, 1'b1};
        end else begin
            credit_count_next_s = credit_count_r;
        end
    end

    // Credit counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit_count_r <= {CountWidth{1'b0}};
        end else begin
            credit_count_r <= credit_count_next_s;
        end
    end

    // Round-robin pointer moves past the winner only when a push actually issues.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r <= {FifoIdWidth{1'b0}};
        end else if (issue_s) begin
            ptr_r <= wrap_idx(grant_idx_s, 32'd1);
        end else begin
            ptr_r <= ptr_r;
        end
    end

    // Registered push; data and id hold their last values between pushes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            push_valid_r   <= 1'b0;
            push_data_r    <= {Width{1'b0}};
            push_fifo_id_r <= {FifoIdWidth{1'b0}};
        end else if (issue_s) begin
            push_valid_r   <= 1'b1;
            push_data_r    <= src_data[grant_idx_s];
            push_fifo_id_r <= grant_idx_s;
        end else begin
            push_valid_r   <= 1'b0;
            push_data_r    <= push_data_r;
            push_fifo_id_r <= push_fifo_id_r;
        end
    end

    assign src_ready            = src_ready_s;
    assign push_sender_in_reset = sender_in_reset_r;
    assign push_valid           = push_valid_r;
    assign push_data            = push_data_r;
    assign push_fifo_id         = push_fifo_id_r;
    assign credit_count         = credit_count_r;
    assign credit_available     = credit_available_s;

    br_fifo_shared_dynamic_push_credit_arb_sender_chk #(
        .NumFifos   (NumFifos),
        .Width      (Width),
        .MaxCredit  (MaxCredit),
        .CountWidth (CountWidth)
    ) u_chk (
        .clk                    (clk),
        .rst                    (rst),
        .src_valid              (src_valid),
        .src_ready              (src_ready_s),
        .src_data               (src_data),
        .push_credit            (push_credit),
        .push_sender_in_reset   (sender_in_reset_r),
        .push_receiver_in_reset (push_receiver_in_reset),
        .issue                  (issue_s),
        .credit_withhold        (credit_withhold),
        .credit_count           (credit_count_r)
    );

endmodule

// File: tb/tb_br_fifo_shared_dynamic_push_credit_arb_sender.sv
// Bench for the push credit sender: directed vector table, then randomized traffic
// compared each cycle against a cycle-level behavioural model.

module tb_br_fifo_shared_dynamic_push_credit_arb_sender;

    localparam int NF  = 4;
    localparam int W   = 8;
    localparam int MC  = 7;
    localparam int IDW = 2;
    localparam int CW  = 3;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NF-1:0]        src_valid;
    logic [NF-1:0]        src_ready;
    logic [NF-1:0][W-1:0] src_data;
    logic                 push_sender_in_reset;
    logic                 push_receiver_in_reset;
    logic                 push_credit;
    logic                 push_valid;
    logic [W-1:0]         push_data;
    logic [IDW-1:0]       push_fifo_id;
    logic                 credit_stall;
    logic [CW-1:0]        credit_withhold;
    logic [CW-1:0]        credit_count;
    logic [CW-1:0]        credit_available;

    int nvec = 0;
    int nmis = 0;

    // behavioural model state
    int         m_count, m_ptr, m_pid;
    logic       m_pv, m_srst;
    logic [7:0] m_pdata;
    logic [3:0] pend;

    typedef struct {
        logic [3:0] v;
        logic       c;
        logic       st;
        logic [2:0] wh;
        logic       rr;
        logic [3:0] rdy;
        int         cnt;
        int         av;
        logic       pv;
        int         pid;
    } vec_t;
    vec_t tbl[36];

    br_fifo_shared_dynamic_push_credit_arb_sender #(
        .NumFifos  (NF),
        .Width     (W),
        .MaxCredit (MC)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .src_valid              (src_valid),
        .src_ready              (src_ready),
        .src_data               (src_data),
        .push_sender_in_reset   (push_sender_in_reset),
        .push_receiver_in_reset (push_receiver_in_reset),
        .push_credit            (push_credit),
        .push_valid             (push_valid),
        .push_data              (push_data),
        .push_fifo_id           (push_fifo_id),
        .credit_stall           (credit_stall),
        .credit_withhold        (credit_withhold),
        .credit_count           (credit_count),
        .credit_available       (credit_available)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Compare current outputs with the model, then advance the model over the coming edge.
    task automatic model_step();
        int g, avail, nc;
        bit can, issue;
        logic [3:0] er;
        avail = (m_count > int'(credit_withhold)) ? m_count - int'(credit_withhold) : 0;
        can = (avail != 0) && !credit_stall && !push_receiver_in_reset && !m_srst;
        g = -1;
        for (int k = 0; k < NF; k++) begin
            if (g < 0 && src_valid[(m_ptr + k) % NF]) g = (m_ptr + k) % NF;
        end
        er = 4'b0000;
        if (can && g >= 0) er[g] = 1'b1;
        chk("src_ready", 32'(src_ready), 32'(er));
        chk("credit_count", 32'(credit_count), 32'(m_count));
        chk("credit_available", 32'(credit_available), 32'(avail));
        chk("push_valid", 32'(push_valid), 32'(m_pv));
        chk("push_data", 32'(push_data), 32'(m_pdata));
        chk("push_fifo_id", 32'(push_fifo_id), 32'(m_pid));
        chk("sender_in_reset", 32'(push_sender_in_reset), 32'(m_srst));
        issue = can && (g >= 0);
        for (int i = 0; i < NF; i++) pend[i] = src_valid[i] && !(issue && g == i);
        if (issue) begin
            m_pv = 1'b1;
            m_pdata = src_data[g];
            m_pid = g;
            m_ptr = (g + 1) % NF;
        end else begin
            m_pv = 1'b0;
        end
        nc = m_count + (push_credit ? 1 : 0) - (issue ? 1 : 0);
        if (push_receiver_in_reset) nc = 0;
        if (nc > MC) nc = MC;
        m_count = nc;
        m_srst = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        src_valid = 4'b0000;
        push_credit = 1'b0;
        credit_stall = 1'b0;
        push_receiver_in_reset = 1'b0;
        credit_withhold = 3'd0;
        pend = 4'b0000;
        #2;
        chk("rst_push_valid", 32'(push_valid), 32'd0);
        chk("rst_push_data", 32'(push_data), 32'd0);
        chk("rst_push_fifo_id", 32'(push_fifo_id), 32'd0);
        chk("rst_credit_count", 32'(credit_count), 32'd0);
        chk("rst_credit_available", 32'(credit_available), 32'd0);
        chk("rst_sender_in_reset", 32'(push_sender_in_reset), 32'd1);
        m_count = 0; m_ptr = 0; m_pid = 0; m_pv = 1'b0; m_pdata = 8'h00; m_srst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        model_step();
        @(posedge clk); #1;
    endtask

    initial begin
        //          v       c     st    wh    rr    rdy     cnt av pv   pid
        tbl[0]  = '{4'b0000, 1'b1, 1'b0, 3'd0, 1'b0, 4'b0000, 0, 0, 1'b0, 0};
        tbl[1]  = '{4'b0000, 1'b1, 1'b0, 3'd0, 1'b0, 4'b0000, 1, 1, 1'b0, 0};
        tbl[2]  = '{4'b0000, 1'b1, 1'b0, 3'd0, 1'b0, 4'b0000, 2, 2, 1'b0, 0};
        tbl[3]  = '{4'b0011, 1'b0, 1'b0, 3'd0, 1'b0, 4'b0001, 3, 3, 1'b0, 0};
        tbl[4]  = '{4'b0011, 1'b0, 1'b0, 3'd0, 1'b0, 4'b0010, 2, 2, 1'b1, 0};
        tbl[5]  = '{4'b0011, 1'b0, 1'b0, 3'd0, 1'b0, 4'b0001, 1, 1, 1'b1, 1};
        tbl[6]  = '{4'b0011, 1'b0, 1'b0, 3'd0, 1'b0, 4'b0000, 0, 0, 1'b1, 0};
        tbl[7]  = '{4'b0000, 1'b0, 1'b0, 3'd0, 1'b0, 4'b0000, 0, 0, 1'b0, 0};
        tbl[8]  = '{4'b0000, 1'b1, 1'b0, 3'd2, 1'b0, 4'b0000, 0, 0, 1'b0, 0};
        tbl[9]  = '{4'b0000, 1'b1, 1'b0, 3'd2, 1'b0, 4'b0000, 1, 0, 1'b0, 0};
        tbl[10] = '{4'b0000, 1'b1, 1'b0, 3'd2, 1'b0, 4'b0000, 2, 0, 1'b0, 0};
        tbl[11] = '{4'b0100, 1'b0, 1'b0, 3'd2, 1'b0, 4'b0100, 3, 1, 1'b0, 0};
        tbl[12] = '{4'b0100, 1'b0, 1'b0, 3'd2, 1'b0, 4'b0000, 2, 0, 1'b1, 2};
        tbl[13] = '{4'b0100, 1'b0, 1'b0, 3'd2, 1'b0, 4'b0000, 2, 0, 1'b0, 2};
        tbl[14] = '{4'b0100, 1'b0, 1'b0, 3'd2, 1'b1, 4'b0000, 2, 0, 1'b0, 2};
        tbl[15] = '{4'b0000, 1'b0, 1'b0, 3'd0, 1'b1, 4'b0000, 0, 0, 1'b0, 2};
        tbl[16] = '{4'b0001, 1'b1, 1'b0, 3'd0, 1'b0, 4'b0000, 0, 0, 1'b0, 2};
        tbl[17] = '{4'b0001, 1'b0, 1'b0, 3'd0, 1'b0, 4'b0001, 1, 1, 1'b0, 2};
        tbl[18] = '{4'b0001, 1'b0, 1'b0, 3'd0, 1'b0, 4'b0000, 0, 0, 1'b1, 0};
        tbl[19] = '{4'b0000, 1'b0, 1'b0, 3'd0, 1'b0, 4'b0000, 0, 0, 1'b0, 0};
        tbl[20] = '{4'b0000, 1'b1, 1'b0, 3'd0, 1'b0, 4'b0000, 0, 0, 1'b0, 0};
        tbl[21] = '{4'b1000, 1'b1, 1'b0, 3'd0, 1'b0, 4'b1000, 1, 1, 1'b0, 0};
        tbl[22] = '{4'b0000, 1'b0, 1'b0, 3'd0, 1'b0, 4'b0000, 1, 1, 1'b1, 3};
        tbl[23] = '{4'b0000, 1'b0, 1'b0, 3'd0, 1'b0, 4'b0000, 1, 1, 1'b0, 3};
        tbl[24] = '{4'b0000, 1'b1, 1'b0, 3'd0, 1'b0, 4'b0000, 1, 1, 1'b0, 3};
        tbl[25] = '{4'b1111, 1'b1, 1'b1, 3'd0, 1'b0, 4'b0000, 2, 2, 1'b0, 3};
        tbl[26] = '{4'b1111, 1'b1, 1'b1, 3'd0, 1'b0, 4'b0000, 3, 3, 1'b0, 3};
        tbl[27] = '{4'b1111, 1'b0, 1'b1, 3'd0, 1'b0, 4'b0000, 4, 4, 1'b0, 3};
        tbl[28] = '{4'b1111, 1'b0, 1'b1, 3'd0, 1'b0, 4'b0000, 4, 4, 1'b0, 3};
        tbl[29] = '{4'b1111, 1'b1, 1'b0, 3'd0, 1'b0, 4'b0001, 4, 4, 1'b0, 3};
        tbl[30] = '{4'b1111, 1'b1, 1'b0, 3'd0, 1'b0, 4'b0010, 4, 4, 1'b1, 0};
        tbl[31] = '{4'b1111, 1'b1, 1'b0, 3'd0, 1'b0, 4'b0100, 4, 4, 1'b1, 1};
        tbl[32] = '{4'b1111, 1'b1, 1'b0, 3'd0, 1'b0, 4'b1000, 4, 4, 1'b1, 2};
        tbl[33] = '{4'b1111, 1'b0, 1'b0, 3'd0, 1'b0, 4'b0001, 4, 4, 1'b1, 3};
        tbl[34] = '{4'b0000, 1'b0, 1'b0, 3'd0, 1'b0, 4'b0000, 3, 3, 1'b1, 0};
        tbl[35] = '{4'b0000, 1'b0, 1'b0, 3'd0, 1'b0, 4'b0000, 3, 3, 1'b0, 0};

        for (int i = 0; i < NF; i++) src_data[i] = 8'hA0 + 8'(i);
        do_reset();

        // directed sequences: credit ramp, cancel, withhold, receiver reset, stall, round robin
        for (int r = 0; r < 36; r++) begin
            src_valid = tbl[r].v;
            push_credit = tbl[r].c;
            credit_stall = tbl[r].st;
            credit_withhold = tbl[r].wh;
            push_receiver_in_reset = tbl[r].rr;
            @(negedge clk);
            chk($sformatf("tbl%0d_ready", r), 32'(src_ready), 32'(tbl[r].rdy));
            chk($sformatf("tbl%0d_count", r), 32'(credit_count), 32'(tbl[r].cnt));
            chk($sformatf("tbl%0d_avail", r), 32'(credit_available), 32'(tbl[r].av));
            chk($sformatf("tbl%0d_pvalid", r), 32'(push_valid), 32'(tbl[r].pv));
            chk($sformatf("tbl%0d_pid", r), 32'(push_fifo_id), 32'(tbl[r].pid));
            if (tbl[r].pv) chk($sformatf("tbl%0d_pdata", r), 32'(push_data), 32'(8'hA0 + 8'(tbl[r].pid)));
            model_step();
            @(posedge clk); #1;
        end

        // randomized traffic honouring the integration rules
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NF; i++) begin
                if (!pend[i]) begin
                    src_valid[i] = ($urandom_range(0, 99) < 60);
                    src_data[i] = 8'($urandom);
                end
            end
            push_credit = !m_srst && (m_count < MC) && ($urandom_range(0, 99) < 55);
            credit_stall = ($urandom_range(0, 9) == 0);
            push_receiver_in_reset = ($urandom_range(0, 39) == 0);
            if (m_count == 0 && $urandom_range(0, 7) == 0) credit_withhold = 3'($urandom_range(0, 3));
            @(negedge clk);
            model_step();
            @(posedge clk); #1;
        end

        // asynchronous reset in the middle of traffic
        do_reset();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
